vend_dispenser: RTL and testbench
=================================

# vend_dispenser

Actuator-side responder for the coin-operated vending FSM. Accepts one dispense request per handshake (item flag plus 2-bit change code) and sequences the product motor and the 5 rs coin hopper. Completes each step against a physical sensor, with a per-step timeout. Sits between the vending controller's out/change outputs and the mechanical drivers; reports completion and sticky faults back to the controller.

## Interface

Parameters:
- TIMEOUT, 64, maximum cycles an actuator stays on waiting for its sensor; legal range 2..1023.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present; accepted in a cycle where req_valid && req_ready.
- req_item  in  1  1 = dispense one item.
- req_change  in  2  change to return: 00 none, 01 = 5 rs (one coin), 10 = 10 rs (two 5 rs coins), 11 illegal.
- req_ready  out  1  high only in IDLE.
- motor_on  out  1  product motor drive.
- item_sensor  in  1  item-drop sensor, synchronous, level-sampled.
- hopper_on  out  1  coin hopper drive; ejects one 5 rs coin per activation.
- coin_sensor  in  1  coin-exit sensor, synchronous, level-sampled.
- done  out  1  one-cycle pulse when a request completes successfully.
- fault  out  1  sticky fault; cleared only by rst.
- fault_code  out  2  00 none, 01 item jam, 10 hopper empty, 11 illegal change code.

## Operation

- States: IDLE, VEND, COIN, GAP, DONE, FAULT.
- On acceptance, latch req_item and coins_left = req_change (0, 1 or 2). The next state is chosen in this priority:
  - req_change == 11 → FAULT, code 11; no actuator runs.
  - req_item → VEND.
  - coins_left > 0 → COIN.
  - otherwise → DONE.
- A request with item = 0 and change = 00 is legal. It produces IDLE → DONE → IDLE.
- VEND:
  - motor_on = 1.
  - item_sensor = 1 → go to COIN if coins_left > 0, else DONE.
  - Timer expiry with no sensor → FAULT, code 01.
- COIN:
  - hopper_on = 1.
  - coin_sensor = 1 → decrement coins_left. Go to GAP if the remaining count > 0, else DONE.
  - Timer expiry with no sensor → FAULT, code 10.
- GAP: one cycle with both drives off, then COIN.
- DONE: done = 1 for one cycle, then IDLE.
- FAULT: all drives off, req_ready = 0, fault = 1, fault_code held. Exit only via rst.
- Timer: cleared on entry to VEND/COIN; counts cycles in the state. Width is ceil(log2(TIMEOUT+1)).
- Sensor highs in IDLE, GAP, DONE and FAULT are ignored.

## Timing

- Reset values: req_ready = 1 (state IDLE), motor_on = 0, hopper_on = 0, done = 0, fault = 0, fault_code = 00, coins_left = 0, timer = 0.
- All outputs are registered or decoded from the state register. No combinational path from any input to any output.
- Accept edge N → actuator on from cycle N+1.
- Sensor high in the k-th active cycle (k = 1..TIMEOUT) → drive low in cycle k+1, and the next state takes effect at that edge.
- Sensor in cycle TIMEOUT counts as success. No sensor through cycle TIMEOUT → FAULT from cycle TIMEOUT+1.
- Best-case latency, accept edge to done pulse:
  - Item only: 2 cycles.
  - Item plus 10 rs with immediate sensors: 5 cycles (VEND, COIN, GAP, COIN, DONE).
- req_ready is low from the cycle after acceptance until the cycle after done. req_valid held high during busy is not consumed.
- rst asserted in any state: at the next edge, all outputs take reset values and the in-flight request is discarded. Coins already ejected are not tracked.

## Configuration

- VEND_RETRY_EN defined: on the first timeout in VEND or COIN, drop the drive for one cycle (reuse GAP), reload the timer, and retry the same step once. A second timeout in that step → FAULT with the step's code. The retry budget resets per step.
- VEND_RETRY_EN undefined: the first timeout → FAULT immediately, as described above.

## Test plan

- Reset, then request item = 1, change = 00, item_sensor high in the 3rd motor cycle → motor_on high 3 cycles, done 1 cycle later, req_ready back 1 cycle after done, hopper_on never high.
- Request item = 1, change = 10, sensors immediate → motor_on 1 cycle, hopper_on 1 cycle, 1 GAP cycle, hopper_on 1 cycle, done at accept+5.
- Request item = 0, change = 01, coin_sensor never rises, TIMEOUT = 64 → hopper_on high exactly 64 cycles, then fault = 1, fault_code = 10, req_ready stuck low.
  - With VEND_RETRY_EN: 64 on, 1 off, 64 on, then the fault.
- Request change = 11 → FAULT next cycle with code 11, motor_on and hopper_on never asserted, no done.
- Mid-COIN rst pulse → all drives low and req_ready = 1 after the edge; a new item-only request then completes normally.
- item_sensor pulses while in IDLE, then a valid item request with the sensor in motor cycle TIMEOUT → no effect while idle, success with done, no fault.

Source files
------------

// File: rtl/vend_dispenser_if.sv
// Request/status channel between the vending controller and the dispenser.
// The controller drives the request side (master); the dispenser answers
// with ready, the done pulse and the sticky fault report (slave).
interface vend_dispenser_if;
  logic       req_valid;
  logic       req_item;
  logic [1:0] req_change;
  logic       req_ready;
  logic       done;
  logic       fault;
  logic [1:0] fault_code;

  modport master (
    output req_valid, req_item, req_change,
    input  req_ready, done, fault, fault_code
  );

  modport slave (
    input  req_valid, req_item, req_change,
    output req_ready, done, fault, fault_code
  );
endinterface

// File: rtl/vend_dispenser.sv
// vend_dispenser: sequences the product motor and the 5 rs coin hopper for
// one accepted request, closing each step on its sensor with a timeout.
// Optional build macro VEND_RETRY_EN: a timed-out step is retried once
// after a one-cycle drive-off gap before the fault is raised.
module vend_dispenser #(
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  vend_dispenser_if.slave  bus,
  output logic             motor_on,
  output logic             hopper_on,
  input  logic             item_sensor,
  input  logic             coin_sensor
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, VEND, COIN, GAP, DONE, FAULT
  } state_t;

  state_t        state, state_nx;
  logic [TW-1:0] timer;
  logic [1:0]    coins_left, coins_nx;
  logic [1:0]    fault_code_q, code_nx;
  logic          expired;

`ifdef VEND_RETRY_EN
  logic retried, retried_nx;
  logic gap_to_vend, gap_to_vend_nx;
`endif

  // The step timer sits on its last allowed cycle; no sensor here means timeout.
  assign expired = (timer == TW'(TIMEOUT - 1));

  // All outputs are decoded from registered state, never from inputs.
  assign motor_on       = (state == VEND);
  assign hopper_on      = (state == COIN);
  assign bus.req_ready  = (state == IDLE);
  assign bus.done       = (state == DONE);
  assign bus.fault      = (state == FAULT);
  assign bus.fault_code = fault_code_q;

  // State, coin count, fault code and step timer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      coins_left   <= 2'b00;
      fault_code_q <= 2'b00;
      timer        <= '0;
    end else begin
      state        <= state_nx;
      coins_left   <= coins_nx;
      fault_code_q <= code_nx;
      if (state_nx != state)
        timer <= '0;
      else if (state == VEND || state == COIN)
        timer <= timer + TW'(1);
    end
  end

`ifdef VEND_RETRY_EN
  // Retry bookkeeping: whether this step already used its retry, and which
  // step the gap cycle must return to.
  always_ff @(posedge clk) begin
    if (rst) begin
      retried     <= 1'b0;
      gap_to_vend <= 1'b0;
    end else begin
      retried     <= retried_nx;
      gap_to_vend <= gap_to_vend_nx;
    end
  end
`endif

  // Next-state logic: acceptance decision, sensor completion and timeouts.
  always_comb begin
    state_nx = state;
    coins_nx = coins_left;
    code_nx  = fault_code_q;
`ifdef VEND_RETRY_EN
    retried_nx     = retried;
    gap_to_vend_nx = gap_to_vend;
`endif
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
`ifdef VEND_RETRY_EN
          retried_nx = 1'b0;
`endif
          if (bus.req_change == 2'b11) begin
            coins_nx = 2'b00;
            code_nx  = 2'b11;
            state_nx = FAULT;
          end else begin
            coins_nx = bus.req_change;
            if (bus.req_item)
              state_nx = VEND;
            else if (bus.req_change != 2'b00)
              state_nx = COIN;
            else
              state_nx = DONE;
          end
        end
      end
      VEND: begin
        if (item_sensor) begin
`ifdef VEND_RETRY_EN
          retried_nx = 1'b0;
`endif
          state_nx = (coins_left != 2'b00) ? COIN : DONE;
        end else if (expired) begin
`ifdef VEND_RETRY_EN
          if (!retried) begin
            retried_nx     = 1'b1;
            gap_to_vend_nx = 1'b1;
            state_nx       = GAP;
          end else begin
            code_nx  = 2'b01;
            state_nx = FAULT;
          end
`else
          code_nx  = 2'b01;
          state_nx = FAULT;
`endif
        end
      end
      COIN: begin
        if (coin_sensor) begin
          coins_nx = coins_left - 2'd1;
`ifdef VEND_RETRY_EN
          retried_nx     = 1'b0;
          gap_to_vend_nx = 1'b0;
`endif
          state_nx = (coins_nx != 2'b00) ? GAP : DONE;
        end else if (expired) begin
`ifdef VEND_RETRY_EN
          if (!retried) begin
            retried_nx     = 1'b1;
            gap_to_vend_nx = 1'b0;
            state_nx       = GAP;
          end else begin
            code_nx  = 2'b10;
            state_nx = FAULT;
          end
`else
          code_nx  = 2'b10;
          state_nx = FAULT;
`endif
        end
      end
      GAP: begin
`ifdef VEND_RETRY_EN
        state_nx = gap_to_vend ? VEND : COIN;
`else
        state_nx = COIN;
`endif
      end
      DONE:    state_nx = IDLE;
      FAULT:   state_nx = FAULT;
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_vend_dispenser.sv
// tb_vend_dispenser: cycle-accurate directed vectors for vend_dispenser,
// plus hand-written sequences for timeouts, illegal change and mid-step reset.
module tb_vend_dispenser;

  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic motor_on, hopper_on;
  logic item_sensor = 1'b0;
  logic coin_sensor = 1'b0;

  int errors = 0;
  int checks = 0;
  int cnt;

  vend_dispenser_if bus ();

  vend_dispenser #(.TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .motor_on    (motor_on),
    .hopper_on   (hopper_on),
    .item_sensor (item_sensor),
    .coin_sensor (coin_sensor)
  );

  always #5 clk = ~clk;

  // Output vector order: {motor, hopper, ready, done, fault, code[1:0]}
  localparam logic [6:0] O_IDLE = 7'b0010000;
  localparam logic [6:0] O_VEND = 7'b1000000;
  localparam logic [6:0] O_COIN = 7'b0100000;
  localparam logic [6:0] O_OFF  = 7'b0000000;
  localparam logic [6:0] O_DONE = 7'b0001000;
  localparam logic [6:0] O_F10  = 7'b0000110;
  localparam logic [6:0] O_F11  = 7'b0000111;

  typedef struct {
    logic       v;
    logic       it;
    logic [1:0] ch;
    logic       is;
    logic       cs;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[19];

  function automatic logic [6:0] outs();
    return {motor_on, hopper_on, bus.req_ready, bus.done, bus.fault, bus.fault_code};
  endfunction

  // Drive one cycle of inputs away from the edge, then sample just after it.
  task automatic applyStimulus(input logic v, input logic it, input logic [1:0] ch,
                               input logic is, input logic cs);
    @(negedge clk);
    bus.req_valid  = v;
    bus.req_item   = it;
    bus.req_change = ch;
    item_sensor    = is;
    coin_sensor    = cs;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [6:0] exp);
    logic [6:0] act;
    act = outs();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b (motor,hopper,ready,done,fault,code)",
               name, act, exp);
    end
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = 1'b0;
    item_sensor   = 1'b0;
    coin_sensor   = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reset_values", O_IDLE);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_item   = 1'b0;
    bus.req_change = 2'b00;

    // item only, sensor in 3rd motor cycle
    vecs[0]  = '{1'b1, 1'b1, 2'b00, 1'b0, 1'b0, O_VEND};
    vecs[1]  = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b0, O_VEND};
    vecs[2]  = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b0, O_VEND};
    vecs[3]  = '{1'b0, 1'b0, 2'b00, 1'b1, 1'b0, O_DONE};
    vecs[4]  = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b0, O_IDLE};
    // item plus 10 rs, immediate sensors; sensor in GAP is ignored
    vecs[5]  = '{1'b1, 1'b1, 2'b10, 1'b0, 1'b0, O_VEND};
    vecs[6]  = '{1'b0, 1'b0, 2'b00, 1'b1, 1'b0, O_COIN};
    vecs[7]  = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b1, O_OFF};
    vecs[8]  = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b1, O_COIN};
    vecs[9]  = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b1, O_DONE};
    vecs[10] = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b0, O_IDLE};
    // empty request, valid held through DONE is not consumed
    vecs[11] = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, O_DONE};
    vecs[12] = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, O_IDLE};
    vecs[13] = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, O_DONE};
    vecs[14] = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b0, O_IDLE};
    // sensors in IDLE ignored
    vecs[15] = '{1'b0, 1'b0, 2'b00, 1'b1, 1'b1, O_IDLE};
    // change only, one coin
    vecs[16] = '{1'b1, 1'b0, 2'b01, 1'b0, 1'b0, O_COIN};
    vecs[17] = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b1, O_DONE};
    vecs[18] = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b0, O_IDLE};

    doReset();

    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].v, vecs[i].it, vecs[i].ch, vecs[i].is, vecs[i].cs);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Hopper never sees a coin: timeout into fault code 10.
    applyStimulus(1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
    cnt = hopper_on ? 1 : 0;
    for (int i = 1; i < TIMEOUT; i++) begin
      applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
      if (hopper_on) cnt++;
    end
    checkValue("hopper_on_cycles", cnt, TIMEOUT);
`ifdef VEND_RETRY_EN
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    checkOutput("retry_gap", O_OFF);
    cnt = 0;
    for (int i = 0; i < TIMEOUT; i++) begin
      applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
      if (hopper_on) cnt++;
    end
    checkValue("retry_hopper_on_cycles", cnt, TIMEOUT);
`endif
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    checkOutput("hopper_fault", O_F10);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 2'b01, 1'b1, 1'b1);
      checkOutput("fault_sticky", O_F10);
    end

    doReset();

    // Illegal change code: straight to fault 11, no actuator, no done.
    applyStimulus(1'b1, 1'b1, 2'b11, 1'b0, 1'b0);
    checkOutput("illegal_change", O_F11);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 2'b01, 1'b1, 1'b1);
      checkOutput("illegal_hold", O_F11);
    end

    doReset();

    // Reset in the middle of a coin step, then a normal item-only request.
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
    checkOutput("coin_before_rst", O_COIN);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    checkOutput("coin_still_on", O_COIN);
    doReset();
    applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
    checkOutput("post_rst_vend", O_VEND);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    checkOutput("post_rst_done", O_DONE);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    checkOutput("post_rst_idle", O_IDLE);

    // Item sensor pulses while idle, then a success in the last motor cycle.
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    checkOutput("idle_pulse_a", O_IDLE);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    checkOutput("idle_pulse_b", O_IDLE);
    applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
    cnt = motor_on ? 1 : 0;
    for (int i = 1; i < TIMEOUT; i++) begin
      applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
      if (motor_on) cnt++;
    end
    checkValue("motor_on_cycles", cnt, TIMEOUT);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    checkOutput("last_cycle_success", O_DONE);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    checkOutput("last_cycle_idle", O_IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
